// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: picks the next PC, issues instruction fetches and
// owns the IF/ID register, holding a redirect until any outstanding fetch drains.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_out,
  output logic [31:0] pc_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect, accept;
  logic [31:0] target, pc_plus4;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;
  assign pc_plus4 = pc_out + 32'd4;
  assign accept   = imem_req & imem_ready & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pend_q  <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    pc_in    = pc_out;
    imem_req = 1'b0;
    if (rst) begin
      pc_in = RESET_VECTOR;
    end else begin
      unique case (state_q)
        BOOT: begin
          pc_in   = RESET_VECTOR;
          state_d = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (redirect) begin
            // A redirect flushes IF/ID even under stall; the in-flight word is dropped.
            valid_d = 1'b0;
            if (accept) begin
              pc_in = target;
            end else begin
              pend_d  = target;
              state_d = DRAIN;
            end
          end else if (accept) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_in   = pc_plus4;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        DRAIN: begin
          // Keep requesting the old address until its response is consumed.
          imem_req = 1'b1;
          if (redirect) begin
            pend_d  = target;
            valid_d = 1'b0;
          end
          if (accept) begin
            pc_in   = redirect ? target : pend_q;
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign imem_addr   = pc_out;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, then random traffic against a
// pending-redirect reference model; the external pc register lives here.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out, pc_in;
  logic        stall, branch_taken, jump, imem_req, imem_ready, if_id_valid;
  logic [31:0] branch_target, jump_target, imem_addr, imem_rdata, if_id_instr, if_id_pc4;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_in(pc_in), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc_out <= pc_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, stall, br, jmp, rdy;
    logic [31:0] bt, jt, rdata;
    logic [31:0] e_addr, e_pc_in;
    logic        e_req, e_valid;
    logic [31:0] e_pc4, e_instr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic rdy, logic [31:0] rd,
                              logic [31:0] ea, logic [31:0] epi, logic er,
                              logic ev, logic [31:0] ep4, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt;
    v.rdy = rdy; v.rdata = rd; v.e_addr = ea; v.e_pc_in = epi; v.e_req = er;
    v.e_valid = ev; v.e_pc4 = ep4; v.e_instr = ei;
    return v;
  endfunction

  task automatic drive(logic r, logic s, logic b, logic [31:0] bt, logic j,
                       logic [31:0] jt, logic rdy, logic [31:0] rd);
    rst = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; imem_ready = rdy; imem_rdata = rd;
  endtask

  // Reference model: a fetch slot with an optional pending redirect.
  logic        m_boot, m_pend_v;
  logic [31:0] m_pend, m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] e_pc_in;
  logic        e_req;

  task automatic model_cycle();
    logic        acc, redir;
    logic [31:0] tgt;
    redir = jump | branch_taken;
    tgt   = jump ? jump_target : branch_target;
    e_pc_in = m_pc;
    e_req   = 1'b0;
    if (rst) begin
      e_pc_in = 32'h0;
      m_boot = 1; m_pend_v = 0; m_pend = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (m_boot) begin
      e_pc_in = 32'h0;
      m_boot  = 0;
    end else begin
      e_req = 1'b1;
      acc   = imem_ready && !stall;
      if (m_pend_v) begin
        if (redir) begin m_pend = tgt; m_valid = 0; end
        if (acc) begin e_pc_in = m_pend; m_pend_v = 0; m_valid = 0; end
      end else if (redir) begin
        m_valid = 0;
        if (acc) e_pc_in = tgt;
        else begin m_pend = tgt; m_pend_v = 1; end
      end else if (acc) begin
        m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1; e_pc_in = m_pc + 4;
      end else if (!stall) begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    // rst stall br bt jmp jt rdy rdata | addr pc_in req | valid pc4 instr
    tv.push_back(mk(1,0,0,0,0,0,1,32'h0,             32'h0,        32'h0,        0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h0,             32'h0,        32'h0,        0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0001,     32'h0,        32'h4,        1, 1, 32'h4,   32'h2000_0001));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0002,     32'h4,        32'h8,        1, 1, 32'h8,   32'h2000_0002));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,1,0,0,0,0,1,32'h3,           32'h8,        32'h8,        1, 1, 32'h8,   32'h2000_0002));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0003,     32'h8,        32'hC,        1, 1, 32'hC,   32'h2000_0003));
    tv.push_back(mk(0,0,1,32'h40,0,0,1,32'hDEAD,     32'hC,        32'h40,       1, 0, 32'hC,   32'h2000_0003));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0004,     32'h40,       32'h44,       1, 1, 32'h44,  32'h2000_0004));
    tv.push_back(mk(0,0,0,0,1,32'h100,0,32'hBAD,     32'h44,       32'h44,       1, 0, 32'h44,  32'h2000_0004));
    tv.push_back(mk(0,0,0,0,0,0,0,32'hBAD,           32'h44,       32'h44,       1, 0, 32'h44,  32'h2000_0004));
    tv.push_back(mk(0,0,0,0,0,0,1,32'hBAD,           32'h44,       32'h100,      1, 0, 32'h44,  32'h2000_0004));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0005,     32'h100,      32'h104,      1, 1, 32'h104, 32'h2000_0005));
    tv.push_back(mk(0,0,1,32'h80,1,32'hABCD_1234,1,32'h1, 32'h104, 32'hABCD_1234, 1, 0, 32'h104, 32'h2000_0005));
    tv.push_back(mk(0,0,0,0,1,32'hFFFF_FFFC,1,32'h1, 32'hABCD_1234, 32'hFFFF_FFFC, 1, 0, 32'h104, 32'h2000_0005));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0006,     32'hFFFF_FFFC, 32'h0,       1, 1, 32'h0,   32'h2000_0006));
    tv.push_back(mk(0,0,1,32'h200,0,0,0,32'h1,       32'h0,        32'h0,        1, 0, 32'h0,   32'h2000_0006));
    tv.push_back(mk(1,0,0,0,0,0,1,32'h1,             32'h0,        32'h0,        0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h1,             32'h0,        32'h0,        0, 0, 32'h0,   32'h0));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h2000_0007,     32'h0,        32'h4,        1, 1, 32'h4,   32'h2000_0007));
    tv.push_back(mk(0,0,0,0,0,0,0,32'h1,             32'h4,        32'h4,        1, 0, 32'h4,   32'h2000_0007));
    tv.push_back(mk(0,1,1,32'h300,0,0,1,32'h1,       32'h4,        32'h4,        1, 0, 32'h4,   32'h2000_0007));
    tv.push_back(mk(0,0,0,0,1,32'h500,0,32'h1,       32'h4,        32'h4,        1, 0, 32'h4,   32'h2000_0007));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h1,             32'h4,        32'h500,      1, 0, 32'h4,   32'h2000_0007));
    tv.push_back(mk(0,0,0,0,0,0,1,32'h9,             32'h500,      32'h504,      1, 1, 32'h504, 32'h9));

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].stall, tv[i].br, tv[i].bt, tv[i].jmp, tv[i].jt, tv[i].rdy, tv[i].rdata);
      #1;
      if (!tv[i].rst) chk($sformatf("v%0d.addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("v%0d.pc_in", i), pc_in, tv[i].e_pc_in);
      chk($sformatf("v%0d.req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), {31'b0, if_id_valid}, {31'b0, tv[i].e_valid});
      chk($sformatf("v%0d.pc4", i), if_id_pc4, tv[i].e_pc4);
      chk($sformatf("v%0d.instr", i), if_id_instr, tv[i].e_instr);
    end

    // Random traffic; the first cycle forces reset so the model starts aligned.
    m_pc = pc_out;
    for (int c = 0; c < 3000; c++) begin
      drive(c == 0 || $urandom_range(99) == 0, $urandom_range(3) == 0,
            $urandom_range(7) == 0, $urandom, $urandom_range(9) == 0, $urandom,
            $urandom_range(1) == 1, $urandom);
      #1;
      model_cycle();
      if (!rst) chk("rnd.addr", imem_addr, m_pc);
      chk("rnd.pc_in", pc_in, e_pc_in);
      chk("rnd.req", {31'b0, imem_req}, {31'b0, e_req});
      @(posedge clk); #1;
      m_pc = e_pc_in;
      chk("rnd.pc_out", pc_out, m_pc);
      chk("rnd.valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("rnd.pc4", if_id_pc4, m_pc4);
      chk("rnd.instr", if_id_instr, m_instr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
